// File: rtl/riscv_lsu.sv
// -----------------------------------------------------------------------------
// riscv_lsu
//
// Load/store unit sitting between the core's data-memory port and a
// multi-cycle SRAM-style bus. One access is in flight at a time: the core is
// stalled from the cycle it presents an aligned request until the bus
// responds, and then sees exactly one DONE cycle in which it commits.
//
// Ports
//   clk           core clock, all state changes on the rising edge
//   rst           synchronous reset, active-low
//   req_valid_i   core presents a data access (held while stall_o=1)
//   req_we_i      1 = store, 0 = load
//   req_addr_i    byte address
//   req_wdata_i   store data (rs2)
//   mem_op_i      funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   stall_o       core must hold PC and request inputs
//   rdata_o       extended load data, valid in DONE
//   misalign_o    current request is misaligned / illegal; never reaches the bus
//   err_o         access timed out; high only in DONE
//   bus_req_o     registered bus request, held until granted
//   bus_we_o      registered bus write enable
//   bus_addr_o    registered word-aligned address
//   bus_wstrb_o   registered byte strobes (0000 for loads)
//   bus_wdata_o   registered lane-replicated store data
//   bus_gnt_i     bus accepted the request this cycle
//   bus_rvalid_i  one response pulse per granted request (reads and writes)
//   bus_rdata_i   read word, valid with bus_rvalid_i
// -----------------------------------------------------------------------------
module riscv_lsu #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [2:0]  mem_op_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o,
  output logic        err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_wstrb_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i
);

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  // Counter value on the last permitted REQ/WAIT cycle. A zero timeout wraps
  // this to all-ones, but the compare is gated off in that case anyway.
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit               TO_EN    = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic [2:0]        r_op;
  logic [1:0]        r_off;

  logic              w_misalign_rule;
  logic              w_accept;
  logic              w_timeout;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  // Unknown funct3 encodings are folded into the misalign trap so the core
  // sees a single "no bus access" path for every illegal request.
  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
    logic bad;
    case (op)
      OP_B, OP_BU: bad = 1'b0;
      OP_H, OP_HU: bad = off[0];
      OP_W:        bad = (off != 2'b00);
      default:     bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] store_strobe(input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] s;
    case (sz)
      2'b00:   s = 4'b0001 << off;
      2'b01:   s = 4'b0011 << {off[1], 1'b0};
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  // Data is replicated into every lane so the strobe alone selects bytes.
  function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] r;
    case (sz)
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] op, input logic [1:0] off,
                                               input logic [31:0] word);
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> {off, 3'b000};
    case (op)
      OP_B:    r = {{24{sh[7]}},  sh[7:0]};
      OP_H:    r = {{16{sh[15]}}, sh[15:0]};
      OP_BU:   r = {24'd0, sh[7:0]};
      OP_HU:   r = {16'd0, sh[15:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Combinational request qualification
  // ---------------------------------------------------------------------------
  assign w_misalign_rule = is_misaligned(mem_op_i, req_addr_i[1:0]);
  assign misalign_o      = req_valid_i & w_misalign_rule;
  assign stall_o         = req_valid_i & ~misalign_o & (r_state != S_DONE);
  assign w_accept        = (r_state == S_IDLE) & req_valid_i & ~w_misalign_rule;
  assign w_timeout       = TO_EN && (r_cnt == TO_LAST);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_REQ;
      // Timeout takes priority over a grant on the same cycle: the access is
      // abandoned before the bus is committed to a response.
      S_REQ: begin
        if (w_timeout)      w_next = S_DONE;
        else if (bus_gnt_i) w_next = S_WAIT;
      end
      // A response on the final cycle still counts as a normal completion.
      S_WAIT: begin
        if (bus_rvalid_i || w_timeout) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Timeout counter: runs only while the access occupies the bus
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (r_state == S_REQ || r_state == S_WAIT) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Bus fields, captured request attributes and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_wstrb_o <= '0;
      bus_wdata_o <= '0;
      rdata_o     <= '0;
      err_o       <= 1'b0;
      r_we        <= 1'b0;
      r_op        <= '0;
      r_off       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= req_we_i;
            bus_addr_o  <= {req_addr_i[31:2], 2'b00};
            bus_wstrb_o <= req_we_i ? store_strobe(mem_op_i[1:0], req_addr_i[1:0]) : 4'b0000;
            bus_wdata_o <= req_we_i ? store_data(mem_op_i[1:0], req_wdata_i) : 32'd0;
            r_we        <= req_we_i;
            r_op        <= mem_op_i;
            r_off       <= req_addr_i[1:0];
            rdata_o     <= '0;
            err_o       <= 1'b0;
          end
        end
        S_REQ: begin
          if (w_timeout) begin
            bus_req_o <= 1'b0;
            err_o     <= 1'b1;
            rdata_o   <= '0;
          end else if (bus_gnt_i) begin
            bus_req_o <= 1'b0;
          end
        end
        S_WAIT: begin
          if (bus_rvalid_i) begin
            if (!r_we) rdata_o <= load_extract(r_op, r_off, bus_rdata_i);
          end else if (w_timeout) begin
            err_o   <= 1'b1;
            rdata_o <= '0;
          end
        end
        S_DONE: begin
          // Result is only meaningful for the single commit cycle.
          rdata_o <= '0;
          err_o   <= 1'b0;
        end
        default: begin
          bus_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
module tb_riscv_lsu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_we_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic [2:0]  mem_op_i = '0;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        misalign_o;
  logic        err_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_wstrb_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i = 1'b0;
  logic        bus_rvalid_i = 1'b0;
  logic [31:0] bus_rdata_i = '0;

  always #5 clk = ~clk;

  riscv_lsu #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_we_i     (req_we_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .mem_op_i     (mem_op_i),
    .stall_o      (stall_o),
    .rdata_o      (rdata_o),
    .misalign_o   (misalign_o),
    .err_o        (err_o),
    .bus_req_o    (bus_req_o),
    .bus_we_o     (bus_we_o),
    .bus_addr_o   (bus_addr_o),
    .bus_wstrb_o  (bus_wstrb_o),
    .bus_wdata_o  (bus_wdata_o),
    .bus_gnt_i    (bus_gnt_i),
    .bus_rvalid_i (bus_rvalid_i),
    .bus_rdata_i  (bus_rdata_i)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One complete access: request, grant after gnt_dly REQ cycles, response
  // after rv_dly WAIT cycles, then the DONE commit cycle.
  task automatic run_access(input string nm, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [2:0] op,
                            input int gnt_dly, input int rv_dly, input logic [31:0] rd,
                            input logic [31:0] exp_rd, input logic [3:0] exp_strb,
                            input logic [31:0] exp_wd);
    exp_t        e;
    logic [31:0] exp_addr;
    exp_addr    = addr & 32'hFFFF_FFFC;
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    mem_op_i    = op;
    #1;
    n_checks++;
    if ({stall_o, misalign_o} !== 2'b10) begin
      n_fail++; $display("FAIL %s idle_stall: got stall=%b misalign=%b want 1 0", nm, stall_o, misalign_o);
    end
    e.rdata = exp_rd; e.err = 1'b0;
    sb.push_back(e);
    next_cycle();
    n_checks++;
    if ({bus_req_o, bus_we_o, stall_o} !== {1'b1, we, 1'b1} || bus_addr_o !== exp_addr || bus_wstrb_o !== exp_strb) begin
      n_fail++;
      $display("FAIL %s req_fields: got req=%b we=%b stall=%b addr=%h strb=%b want 1 %b 1 %h %b",
               nm, bus_req_o, bus_we_o, stall_o, bus_addr_o, bus_wstrb_o, we, exp_addr, exp_strb);
    end
    if (we) begin
      n_checks++;
      if (bus_wdata_o !== exp_wd) begin
        n_fail++; $display("FAIL %s wdata: got %h want %h", nm, bus_wdata_o, exp_wd);
      end
    end
    for (int i = 1; i < gnt_dly; i++) next_cycle();
    bus_gnt_i = 1'b1;
    next_cycle();
    bus_gnt_i = 1'b0;
    n_checks++;
    if ({bus_req_o, stall_o} !== 2'b01) begin
      n_fail++; $display("FAIL %s wait_state: got req=%b stall=%b want 0 1", nm, bus_req_o, stall_o);
    end
    for (int i = 1; i < rv_dly; i++) next_cycle();
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = rd;
    next_cycle();
    bus_rvalid_i = 1'b0;
    bus_rdata_i  = '0;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++; $display("FAIL %s done: scoreboard empty", nm);
    end else begin
      e = sb.pop_front();
      if (stall_o !== 1'b0 || rdata_o !== e.rdata || err_o !== e.err) begin
        n_fail++;
        $display("FAIL %s done: got stall=%b rdata=%h err=%b want 0 %h %b", nm, stall_o, rdata_o, err_o, e.rdata, e.err);
      end
    end
    req_valid_i = 1'b0;
    next_cycle();
    n_checks++;
    if ({err_o, bus_req_o, stall_o} !== 3'b000) begin
      n_fail++; $display("FAIL %s back_idle: got err=%b req=%b stall=%b want 0 0 0", nm, err_o, bus_req_o, stall_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    next_cycle();
    next_cycle();
    n_checks++;
    if ({bus_req_o, bus_we_o, stall_o, err_o, misalign_o} !== 5'b0 || bus_addr_o !== 32'd0 ||
        bus_wstrb_o !== 4'd0 || bus_wdata_o !== 32'd0 || rdata_o !== 32'd0) begin
      n_fail++;
      $display("FAIL reset: got req=%b we=%b stall=%b err=%b addr=%h strb=%b wd=%h rd=%h want all 0",
               bus_req_o, bus_we_o, stall_o, err_o, bus_addr_o, bus_wstrb_o, bus_wdata_o, rdata_o);
    end
    rst = 1'b1;
    next_cycle();
  endtask

  task automatic test_lw();
    run_access("lw", 1'b0, 32'h8000_0010, 32'h0, 3'b010, 1, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b0000, 32'h0);
    run_access("lw_slow", 1'b0, 32'h8000_0014, 32'h0, 3'b010, 2, 1, 32'h1357_9BDF, 32'h1357_9BDF, 4'b0000, 32'h0);
  endtask

  task automatic test_loads();
    run_access("lb",  1'b0, 32'h8000_0003, 32'h0, 3'b000, 1, 1, 32'h80FF_7F01, 32'hFFFF_FF80, 4'b0000, 32'h0);
    run_access("lbu", 1'b0, 32'h8000_0003, 32'h0, 3'b100, 1, 1, 32'h80FF_7F01, 32'h0000_0080, 4'b0000, 32'h0);
    run_access("lh",  1'b0, 32'h8000_0002, 32'h0, 3'b001, 1, 1, 32'h80FF_7F01, 32'hFFFF_80FF, 4'b0000, 32'h0);
    run_access("lhu", 1'b0, 32'h8000_0002, 32'h0, 3'b101, 1, 2, 32'h80FF_7F01, 32'h0000_80FF, 4'b0000, 32'h0);
    run_access("lb1", 1'b0, 32'h8000_0001, 32'h0, 3'b000, 1, 1, 32'h80FF_7F01, 32'h0000_007F, 4'b0000, 32'h0);
    run_access("lh0", 1'b0, 32'h8000_0000, 32'h0, 3'b001, 1, 1, 32'h80FF_7F01, 32'h0000_7F01, 4'b0000, 32'h0);
  endtask

  task automatic test_stores();
    run_access("sb", 1'b1, 32'h8000_0101, 32'h0000_00AB, 3'b000, 1, 1, 32'hFFFF_FFFF, 32'h0, 4'b0010, 32'hABAB_ABAB);
    run_access("sh", 1'b1, 32'h8000_0102, 32'h0000_1234, 3'b001, 1, 1, 32'hFFFF_FFFF, 32'h0, 4'b1100, 32'h1234_1234);
    run_access("sw", 1'b1, 32'h8000_0104, 32'hCAFE_F00D, 3'b010, 2, 1, 32'hFFFF_FFFF, 32'h0, 4'b1111, 32'hCAFE_F00D);
    run_access("sb3", 1'b1, 32'h8000_0107, 32'h5566_77C3, 3'b000, 1, 1, 32'h0, 32'h0, 4'b1000, 32'hC3C3_C3C3);
  endtask

  task automatic test_misalign();
    logic [31:0] addrs [6] = '{32'h8000_0002, 32'h8000_0001, 32'h8000_0003, 32'h8000_0000, 32'h8000_0000, 32'h8000_0001};
    logic [2:0]  ops   [6] = '{3'b010, 3'b001, 3'b101, 3'b011, 3'b110, 3'b111};
    req_valid_i = 1'b0;
    req_addr_i  = 32'h8000_0002;
    mem_op_i    = 3'b010;
    #1;
    n_checks++;
    if (misalign_o !== 1'b0) begin
      n_fail++; $display("FAIL misalign_novalid: got %b want 0", misalign_o);
    end
    for (int k = 0; k < 6; k++) begin
      req_valid_i = 1'b1;
      req_we_i    = k[0];
      req_addr_i  = addrs[k];
      mem_op_i    = ops[k];
      #1;
      n_checks++;
      if ({misalign_o, stall_o} !== 2'b10) begin
        n_fail++; $display("FAIL misalign_%0d comb: got misalign=%b stall=%b want 1 0", k, misalign_o, stall_o);
      end
      next_cycle();
      next_cycle();
      n_checks++;
      if ({bus_req_o, stall_o, misalign_o} !== 3'b001) begin
        n_fail++; $display("FAIL misalign_%0d idle: got req=%b stall=%b misalign=%b want 0 0 1", k, bus_req_o, stall_o, misalign_o);
      end
    end
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    next_cycle();
  endtask

  task automatic test_timeout();
    exp_t e;
    req_valid_i = 1'b1;
    req_we_i    = 1'b0;
    req_addr_i  = 32'h8000_0020;
    mem_op_i    = 3'b010;
    e.rdata = 32'h0; e.err = 1'b1;
    sb.push_back(e);
    for (int i = 0; i < TO; i++) begin
      // a stray response while still requesting must not end the access
      bus_rvalid_i = (i == 1);
      bus_rdata_i  = 32'h1111_2222;
      next_cycle();
      n_checks++;
      if ({bus_req_o, stall_o, err_o} !== 3'b110) begin
        n_fail++; $display("FAIL timeout_req%0d: got req=%b stall=%b err=%b want 1 1 0", i, bus_req_o, stall_o, err_o);
      end
    end
    bus_rvalid_i = 1'b0;
    next_cycle();
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++; $display("FAIL timeout_done: scoreboard empty");
    end else begin
      e = sb.pop_front();
      if ({bus_req_o, stall_o} !== 2'b00 || rdata_o !== e.rdata || err_o !== e.err) begin
        n_fail++;
        $display("FAIL timeout_done: got req=%b stall=%b rdata=%h err=%b want 0 0 %h %b", bus_req_o, stall_o, rdata_o, err_o, e.rdata, e.err);
      end
    end
    req_valid_i  = 1'b0;
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'hBAD0_BAD0;
    next_cycle();
    next_cycle();
    bus_rvalid_i = 1'b0;
    bus_rdata_i  = '0;
    n_checks++;
    if ({bus_req_o, err_o, stall_o} !== 3'b000) begin
      n_fail++; $display("FAIL timeout_late_rvalid: got req=%b err=%b stall=%b want 0 0 0", bus_req_o, err_o, stall_o);
    end
    run_access("after_timeout", 1'b0, 32'h8000_0024, 32'h0, 3'b010, 1, 1, 32'h0BAD_F00D, 32'h0BAD_F00D, 4'b0000, 32'h0);
  endtask

  task automatic test_reset_mid();
    req_valid_i = 1'b1;
    req_we_i    = 1'b1;
    req_addr_i  = 32'h8000_0044;
    req_wdata_i = 32'hA5A5_5A5A;
    mem_op_i    = 3'b010;
    next_cycle();
    bus_gnt_i = 1'b1;
    next_cycle();
    bus_gnt_i = 1'b0;
    rst = 1'b0;
    next_cycle();
    n_checks++;
    if (bus_req_o !== 1'b0 || stall_o !== req_valid_i || err_o !== 1'b0 || rdata_o !== 32'd0 ||
        bus_wstrb_o !== 4'd0 || bus_addr_o !== 32'd0 || bus_we_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got req=%b stall=%b err=%b rd=%h strb=%b addr=%h we=%b want 0 %b 0 0 0 0 0",
               bus_req_o, stall_o, err_o, rdata_o, bus_wstrb_o, bus_addr_o, bus_we_o, req_valid_i);
    end
    rst = 1'b1;
    req_valid_i = 1'b0;
    next_cycle();
    run_access("after_reset", 1'b0, 32'h8000_0048, 32'h0, 3'b010, 1, 1, 32'h7654_3210, 32'h7654_3210, 4'b0000, 32'h0);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      logic [31:0] w;
      w = $urandom;
      run_access("b2b_lw", 1'b0, 32'h8000_0200 + 32'(k * 4), 32'h0, 3'b010, 1, 1, w, w, 4'b0000, 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lw();
    test_loads();
    test_stores();
    test_misalign();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
Load/store unit placed between the core's data-memory port and a multi-cycle SRAM-style data bus. It replaces the core's single-cycle data_mem connection.
- Stalls the core until each access completes.
- Generates byte strobes and lane-replicated write data for stores.
- Extracts and sign/zero-extends load data.
- Detects misaligned accesses and bus timeouts.

Parameters:
TIMEOUT_CYCLES, 64, cycles spent in REQ+WAIT before the access is aborted with err_o; 0 disables the timeout.
CNT_W, 8, width of the timeout counter; must satisfy TIMEOUT_CYCLES < 2^CNT_W.

Ports:
clk  input  1  core clock; all state updates on rising edge
rst  input  1  synchronous reset, active-low (0 = reset), sampled on rising clk
req_valid_i  input  1  core requests a data access this cycle; held stable while stall_o=1
req_we_i  input  1  1 = store, 0 = load
req_addr_i  input  32  byte address (core ALU result)
req_wdata_i  input  32  store data (rs2 value)
mem_op_i  input  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU
stall_o  output  1  core must hold PC and inputs
rdata_o  output  32  extended load data, valid while state=DONE
misalign_o  output  1  combinational: current request is misaligned; no bus access is made
err_o  output  1  access timed out; high only in DONE
bus_req_o  output  1  bus request, registered
bus_we_o  output  1  bus write, registered
bus_addr_o  output  32  word-aligned address ({addr[31:2],2'b00}), registered
bus_wstrb_o  output  4  byte strobes, registered; 0000 for loads
bus_wdata_o  output  32  lane-replicated store data, registered
bus_gnt_i  input  1  bus accepted request this cycle (valid only while bus_req_o=1)
bus_rvalid_i  input  1  response or data return; one pulse per granted request, reads and writes
bus_rdata_i  input  32  read word, valid with bus_rvalid_i

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE. Reset (rst=0 at an edge) forces:
  - state=IDLE, counter=0
  - bus_req_o=0, bus_we_o=0, bus_wstrb_o=0, bus_addr_o=0, bus_wdata_o=0
  - rdata_o=0, err_o=0
- Misalign rule:
  - H/HU with addr[0]=1 is misaligned.
  - W with addr[1:0]≠00 is misaligned.
  - Any mem_op outside the five listed encodings is treated as misaligned.
  - misalign_o = req_valid_i & rule, in any state.
  - A misaligned request in IDLE stays in IDLE and forces stall_o=0; the core traps.
- stall_o = req_valid_i & ~misalign_o & (state≠DONE). Combinational.
- IDLE transition: on an aligned req_valid_i, register the bus fields and go to REQ.
- Store fields:
  - strobe: B = 0001<<addr[1:0]; H = 0011<<{addr[1],1'b0}; W = 1111.
  - wdata: B = {4{wdata[7:0]}}; H = {2{wdata[15:0]}}; W = wdata.
- REQ: bus_req_o=1 until bus_gnt_i=1. On grant, go to WAIT and drop bus_req_o the next cycle.
- WAIT: on bus_rvalid_i, register rdata_o and go to DONE. rvalid in the same cycle as gnt is not allowed by the bus protocol.
- Load extraction:
  - shift bus_rdata_i right by addr[1:0]*8.
  - B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
  - Stores leave rdata_o at 0.
- DONE: lasts one cycle, stall_o=0, core commits. Next state is IDLE; a request present in the following cycle is treated as new.
- Minimum latency: request in cycle c, gnt in c+1, rvalid in c+2, DONE in c+3. stall_o is high for c..c+2.
- Timeout:
  - the counter increments each cycle in REQ or WAIT and clears in IDLE.
  - when counter == TIMEOUT_CYCLES−1 without completion, go to DONE with err_o=1, rdata_o=0, bus_req_o=0.
  - a late bus_rvalid_i arriving in IDLE or DONE is ignored.
- bus_rvalid_i in IDLE or REQ is ignored.
- If req_valid_i drops mid-access (protocol violation), the access still completes. stall_o follows its formula.
- Reset mid-access: abort immediately; next cycle is IDLE with all outputs at reset values.

Test Plan:
- LW addr 0x80000010, gnt at +1, rvalid at +2, rdata 0xDEADBEEF -> bus_addr 0x80000010, wstrb 0000, stall high 3 cycles, rdata_o=0xDEADBEEF in DONE.
- LB/LBU addr 0x..03 with rdata 0x80FF7F01 -> LB gives 0xFFFFFF80, LBU gives 0x00000080. LH addr 0x..02 gives 0xFFFF80FF.
- SB addr 0x..01, wdata 0x000000AB -> wstrb 0010, bus_wdata 0xABABABAB. SH addr 0x..02, wdata 0x1234 -> wstrb 1100, wdata 0x12341234.
- LW addr 0x..02 -> misalign_o=1, stall_o=0, bus_req_o never asserted, state stays IDLE.
- TIMEOUT_CYCLES=4, gnt never asserted -> DONE after 4 REQ cycles, err_o=1, rdata_o=0. A late rvalid is ignored.
- rst=0 while in WAIT -> next cycle bus_req_o=0, stall_o=req_valid_i. A new LW then completes normally.
